// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage pipeline.
// Owns the data memory and supports word, halfword and byte loads and stores
// with a LAT-cycle access latency. It stalls upstream while an access is in
// flight, resolves branches toward IF and drives the MEM/WB register.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   WB[1:0]             writeback control from EX/MEM
//   MEM[4:0]            [4]=Branch [3]=MemRead [2]=MemWrite [1:0]=size
//   ADDER, Zero         branch target and ALU zero flag
//   alu, read_data_2    byte address / ALU result, and store data
//   dest                destination register
//   PCSrc, branch_target, stall   combinational outputs toward IF and upstream
//   WBOut, read_dataOut, aluOut, destOut, misalign   MEM/WB register outputs
module mem_access_stage #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LAT    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  WB,
   input  logic [4:0]  MEM,
   input  logic [31:0] ADDER,
   input  logic        Zero,
   input  logic [31:0] alu,
   input  logic [31:0] read_data_2,
   input  logic [4:0]  dest,
   output logic        PCSrc,
   output logic [31:0] branch_target,
   output logic        stall,
   output logic [1:0]  WBOut,
   output logic [31:0] read_dataOut,
   output logic [31:0] aluOut,
   output logic [4:0]  destOut,
   output logic        misalign
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = (LAT > 2) ? $clog2(LAT - 1) : 1;
   localparam bit          MULTI = (LAT > 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LAT > 1) ? (LAT - 2) : 0);

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_UBYTE = 2'b11;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0]       mem_q [DEPTH];

   logic [ADDR_W-1:0] idx_c;
   logic [1:0]        size_c;
   logic              mem_op_c, is_wr_c, misal_c, aligned_c, commit_c, we_c;
   logic [31:0]       word_c, load_c, wdata_c;
   logic [15:0]       half_c;
   logic [7:0]        byte_c;

   logic [1:0]        nxt_wb;
   logic [31:0]       nxt_rd, nxt_alu;
   logic [4:0]        nxt_dest;
   logic              nxt_mis;

   // Address bits above the memory depth are ignored; addresses wrap.
   logic              unused_alu_hi;
   assign unused_alu_hi = ^alu[31:ADDR_W+2];

   // Op decode; a combined read+write is treated as a write only.
   assign size_c    = MEM[1:0];
   assign mem_op_c  = MEM[3] | MEM[2];
   assign is_wr_c   = MEM[2];
   assign misal_c   = mem_op_c & (((size_c == SZ_WORD) && (alu[1:0] != 2'b00)) ||
                                  ((size_c == SZ_HALF) && alu[0]));
   assign aligned_c = mem_op_c & ~misal_c;
   assign idx_c     = alu[ADDR_W+1:2];

   // Access commits on the last cycle of its occupancy.
   assign commit_c  = !MULTI || ((state_q == BUSY) && (cnt_q == '0));

   assign stall         = aligned_c & MULTI & ~((state_q == BUSY) && (cnt_q == '0));
   assign PCSrc         = MEM[4] & Zero & ~stall;
   assign branch_target = ADDER;

   // Load path: little-endian lane select and extension.
   always_comb begin : load_ext
      word_c = mem_q[idx_c];
      half_c = alu[1] ? word_c[31:16] : word_c[15:0];
      byte_c = word_c[{alu[1:0], 3'b000} +: 8];
      load_c = word_c;
      case (size_c)
         SZ_WORD:  load_c = word_c;
         SZ_HALF:  load_c = {{16{half_c[15]}}, half_c};
         SZ_BYTE:  load_c = {{24{byte_c[7]}}, byte_c};
         SZ_UBYTE: load_c = {24'h0, byte_c};
         default:  load_c = word_c;
      endcase
   end

   // Store path: merge the addressed lanes into the current word.
   always_comb begin : store_merge
      wdata_c = word_c;
      case (size_c)
         SZ_WORD: wdata_c = read_data_2;
         SZ_HALF: wdata_c[{alu[1], 4'b0000} +: 16] = read_data_2[15:0];
         default: wdata_c[{alu[1:0], 3'b000} +: 8] = read_data_2[7:0];
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state: count down the remaining latency of a multi-cycle access.
   always_comb begin : next_state
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (aligned_c && MULTI) begin
               state_d = BUSY;
               cnt_d   = CNT_INIT;
            end
         end
         BUSY: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else             state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM outputs: next MEM/WB contents and memory write enable.
   always_comb begin : out_comb
      nxt_wb   = WB;
      nxt_rd   = '0;
      nxt_alu  = alu;
      nxt_dest = dest;
      nxt_mis  = 1'b0;
      we_c     = 1'b0;
      if (misal_c) begin
         nxt_wb   = '0;
         nxt_alu  = '0;
         nxt_dest = '0;
         nxt_mis  = 1'b1;
      end else if (aligned_c) begin
         if (commit_c) begin
            // Gated by reset so an aborted access never writes.
            we_c = is_wr_c & ~reset;
            if (!is_wr_c) nxt_rd = load_c;
         end else begin
            nxt_wb   = '0;
            nxt_alu  = '0;
            nxt_dest = '0;
         end
      end
   end

   // Data memory; contents are not reset.
   always_ff @(posedge clk) begin
      if (we_c) mem_q[idx_c] <= wdata_c;
   end

   // MEM/WB pipeline register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         WBOut        <= '0;
         read_dataOut <= '0;
         aluOut       <= '0;
         destOut      <= '0;
         misalign     <= 1'b0;
      end else begin
         WBOut        <= nxt_wb;
         read_dataOut <= nxt_rd;
         aluOut       <= nxt_alu;
         destOut      <= nxt_dest;
         misalign     <= nxt_mis;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: three instances with LAT=1, 3 and 4.
module tb_mem_access_stage;

   logic        clk;
   logic        rst   [3];
   logic [1:0]  wb    [3];
   logic [4:0]  mctl  [3];
   logic [31:0] adder [3];
   logic        zero  [3];
   logic [31:0] alu   [3];
   logic [31:0] rd2   [3];
   logic [4:0]  dst   [3];
   logic        pcsrc [3];
   logic [31:0] btgt  [3];
   logic        stl   [3];
   logic [1:0]  wbo   [3];
   logic [31:0] rdo   [3];
   logic [31:0] aluo  [3];
   logic [4:0]  dsto  [3];
   logic        mis   [3];

   int checks   = 0;
   int failures = 0;

   localparam logic [4:0] NOP = 5'b00000;
   localparam logic [4:0] SW  = 5'b00100;
   localparam logic [4:0] SB  = 5'b00110;
   localparam logic [4:0] LW  = 5'b01000;
   localparam logic [4:0] LH  = 5'b01001;
   localparam logic [4:0] LB  = 5'b01010;
   localparam logic [4:0] LBU = 5'b01011;
   localparam logic [4:0] BEQ = 5'b10000;

   mem_access_stage #(.ADDR_W(8), .LAT(1)) u_lat1 (
      .clk(clk), .reset(rst[0]), .WB(wb[0]), .MEM(mctl[0]), .ADDER(adder[0]),
      .Zero(zero[0]), .alu(alu[0]), .read_data_2(rd2[0]), .dest(dst[0]),
      .PCSrc(pcsrc[0]), .branch_target(btgt[0]), .stall(stl[0]), .WBOut(wbo[0]),
      .read_dataOut(rdo[0]), .aluOut(aluo[0]), .destOut(dsto[0]), .misalign(mis[0]));

   mem_access_stage #(.ADDR_W(8), .LAT(3)) u_lat3 (
      .clk(clk), .reset(rst[1]), .WB(wb[1]), .MEM(mctl[1]), .ADDER(adder[1]),
      .Zero(zero[1]), .alu(alu[1]), .read_data_2(rd2[1]), .dest(dst[1]),
      .PCSrc(pcsrc[1]), .branch_target(btgt[1]), .stall(stl[1]), .WBOut(wbo[1]),
      .read_dataOut(rdo[1]), .aluOut(aluo[1]), .destOut(dsto[1]), .misalign(mis[1]));

   mem_access_stage #(.ADDR_W(8), .LAT(4)) u_lat4 (
      .clk(clk), .reset(rst[2]), .WB(wb[2]), .MEM(mctl[2]), .ADDER(adder[2]),
      .Zero(zero[2]), .alu(alu[2]), .read_data_2(rd2[2]), .dest(dst[2]),
      .PCSrc(pcsrc[2]), .branch_target(btgt[2]), .stall(stl[2]), .WBOut(wbo[2]),
      .read_dataOut(rdo[2]), .aluOut(aluo[2]), .destOut(dsto[2]), .misalign(mis[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input int i, input logic [4:0] m, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] w, input logic [4:0] ds);
      mctl[i] = m;
      alu[i]  = a;
      rd2[i]  = d;
      wb[i]   = w;
      dst[i]  = ds;
   endtask

   // Present an op at the next negedge and hold it for n rising edges.
   task automatic run_op(input int i, input int n, input logic [4:0] m, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] w, input logic [4:0] ds);
      @(negedge clk);
      drv(i, m, a, d, w, ds);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i]   = 1'b1;
         adder[i] = '0;
         zero[i]  = 1'b0;
         drv(i, NOP, 32'h0, 32'h0, 2'b00, 5'd0);
      end

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_wbo",  32'(wbo[0]),  32'h0);
      chk("rst_rdo",  rdo[0],       32'h0);
      chk("rst_aluo", aluo[0],      32'h0);
      chk("rst_dsto", 32'(dsto[0]), 32'h0);
      chk("rst_mis",  32'(mis[0]),  32'h0);
      chk("rst_stall3", 32'(stl[1]), 32'h0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;

      // 1: LAT=1 store then load
      drv(0, SW, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0);
      #1 chk("t1_sw_stall", 32'(stl[0]), 32'h0);
      @(posedge clk); #1;
      chk("t1_sw_wbo", 32'(wbo[0]), 32'h0);
      @(negedge clk);
      drv(0, LW, 32'h10, 32'h0, 2'b11, 5'd5);
      #1 chk("t1_lw_stall", 32'(stl[0]), 32'h0);
      @(posedge clk); #1;
      chk("t1_lw_rdo",  rdo[0],       32'hDEADBEEF);
      chk("t1_lw_wbo",  32'(wbo[0]),  32'h3);
      chk("t1_lw_dsto", 32'(dsto[0]), 32'h5);
      chk("t1_lw_aluo", aluo[0],      32'h10);

      // 2: byte stores and loads with extension
      run_op(0, 1, SW,  32'h20, 32'h0,        2'b00, 5'd0);
      run_op(0, 1, SB,  32'h21, 32'h1234567F, 2'b00, 5'd0);
      run_op(0, 1, SB,  32'h22, 32'hFFFFFF80, 2'b00, 5'd0);
      run_op(0, 1, LB,  32'h22, 32'h0, 2'b11, 5'd1);
      chk("t2_lb",  rdo[0], 32'hFFFFFF80);
      run_op(0, 1, LBU, 32'h22, 32'h0, 2'b11, 5'd1);
      chk("t2_lbu", rdo[0], 32'h00000080);
      run_op(0, 1, LW,  32'h20, 32'h0, 2'b11, 5'd1);
      chk("t2_lw",  rdo[0], 32'h00807F00);
      run_op(0, 1, LH,  32'h20, 32'h0, 2'b11, 5'd1);
      chk("t2_lh_lo", rdo[0], 32'h00007F00);
      run_op(0, 1, LH,  32'h22, 32'h0, 2'b11, 5'd1);
      chk("t2_lh_hi", rdo[0], 32'h00000080);

      // 4: misaligned store is dropped
      run_op(0, 1, SW, 32'h10, 32'h11111111, 2'b00, 5'd0);
      @(negedge clk);
      drv(0, SW, 32'h12, 32'h22222222, 2'b11, 5'd3);
      #1 chk("t4_mis_stall", 32'(stl[0]), 32'h0);
      @(posedge clk); #1;
      chk("t4_mis_flag", 32'(mis[0]), 32'h1);
      chk("t4_mis_wbo",  32'(wbo[0]), 32'h0);
      chk("t4_mis_rdo",  rdo[0],      32'h0);
      run_op(0, 1, LW, 32'h10, 32'h0, 2'b11, 5'd2);
      chk("t4_mis_clr", 32'(mis[0]), 32'h0);
      chk("t4_mem_kept", rdo[0], 32'h11111111);

      // 5: branch resolution and non-memory pass-through
      @(negedge clk);
      drv(0, BEQ, 32'h1234, 32'h0, 2'b10, 5'd7);
      adder[0] = 32'h40;
      zero[0]  = 1'b1;
      #1;
      chk("t5_pcsrc1", 32'(pcsrc[0]), 32'h1);
      chk("t5_target", btgt[0], 32'h40);
      zero[0] = 1'b0;
      #1 chk("t5_pcsrc0", 32'(pcsrc[0]), 32'h0);
      @(posedge clk); #1;
      chk("t5_pass_wbo",  32'(wbo[0]),  32'h2);
      chk("t5_pass_aluo", aluo[0],      32'h1234);
      chk("t5_pass_dsto", 32'(dsto[0]), 32'h7);
      chk("t5_pass_rdo",  rdo[0],       32'h0);

      // 3: LAT=3 stall sequence and load latency
      run_op(1, 3, SW, 32'h30, 32'hCAFEF00D, 2'b00, 5'd0);
      @(negedge clk);
      drv(1, LW, 32'h30, 32'h0, 2'b11, 5'd9);
      #1 chk("t3_stall_c1", 32'(stl[1]), 32'h1);
      @(posedge clk); #1;
      chk("t3_wbo_e1", 32'(wbo[1]), 32'h0);
      @(negedge clk); #1;
      chk("t3_stall_c2", 32'(stl[1]), 32'h1);
      @(posedge clk); #1;
      chk("t3_wbo_e2", 32'(wbo[1]), 32'h0);
      @(negedge clk); #1;
      chk("t3_stall_c3", 32'(stl[1]), 32'h0);
      @(posedge clk); #1;
      chk("t3_wbo_e3",  32'(wbo[1]),  32'h3);
      chk("t3_rdo_e3",  rdo[1],       32'hCAFEF00D);
      chk("t3_dsto_e3", 32'(dsto[1]), 32'h9);
      @(negedge clk);
      drv(1, NOP, 32'h99, 32'h0, 2'b01, 5'd4);
      #1 chk("t3_next_stall", 32'(stl[1]), 32'h0);
      @(posedge clk); #1;
      chk("t3_next_wbo",  32'(wbo[1]), 32'h1);
      chk("t3_next_aluo", aluo[1],     32'h99);

      // 6: LAT=4 reset during BUSY aborts the store
      run_op(2, 4, SW, 32'h8, 32'h12345678, 2'b00, 5'd0);
      @(negedge clk);
      drv(2, SW, 32'h8, 32'hAAAA5555, 2'b00, 5'd0);
      #1 chk("t6_stall_c1", 32'(stl[2]), 32'h1);
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("t6_stall_c2", 32'(stl[2]), 32'h1);
      @(posedge clk); #1;
      @(negedge clk); #2;
      rst[2] = 1'b1;
      #1;
      chk("t6_rst_wbo",  32'(wbo[2]),  32'h0);
      chk("t6_rst_rdo",  rdo[2],       32'h0);
      chk("t6_rst_aluo", aluo[2],      32'h0);
      chk("t6_rst_dsto", 32'(dsto[2]), 32'h0);
      chk("t6_rst_mis",  32'(mis[2]),  32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      drv(2, NOP, 32'h0, 32'h0, 2'b00, 5'd0);
      rst[2] = 1'b0;
      #1 chk("t6_rst_stall", 32'(stl[2]), 32'h0);
      run_op(2, 4, LW, 32'h8, 32'h0, 2'b11, 5'd6);
      chk("t6_prior_val", rdo[2], 32'h12345678);
      chk("t6_lw_wbo", 32'(wbo[2]), 32'h3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
